// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   - ctrl_state_t : sequencing states (FETCH, EXEC, MEM, HALT)
//   - OP_* / FN_*  : MIPS-subset opcode and R-type funct codes
//   - ALU_*        : alu_operation encodings driven to the datapath
package ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        HALT
    } ctrl_state_t;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // alu_operation encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: purely combinational instruction decode.
//   in : inst[XLEN-1:0], zero, negative (ALU flags for branch resolution)
//   out: datapath selects (reg_dest, alu_src, mem_or_reg, pc_or_mem, branch,
//        jump, jump_register, does_shift_amount_need, is_unsigned,
//        alu_operation[3:0]) and class flags (is_mem, is_load, is_store,
//        writes_reg, is_syscall, illegal).
// Unknown encodings raise illegal and leave writes_reg/is_mem low, so the
// controller retires them as a NOP.
module inst_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] inst,
    input  logic            zero,
    input  logic            negative,
    output logic            reg_dest,
    output logic            alu_src,
    output logic            mem_or_reg,
    output logic            pc_or_mem,
    output logic            branch,
    output logic            jump,
    output logic            jump_register,
    output logic            does_shift_amount_need,
    output logic            is_unsigned,
    output logic [3:0]      alu_operation,
    output logic            is_mem,
    output logic            is_load,
    output logic            is_store,
    output logic            writes_reg,
    output logic            is_syscall,
    output logic            illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_inst_bits;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_inst_bits = ^inst;

    always_comb begin
        reg_dest               = 1'b0;
        alu_src                = 1'b0;
        mem_or_reg             = 1'b0;
        pc_or_mem              = 1'b0;
        branch                 = 1'b0;
        jump                   = 1'b0;
        jump_register          = 1'b0;
        does_shift_amount_need = 1'b0;
        is_unsigned            = 1'b0;
        alu_operation          = ALU_ADD;
        is_mem                 = 1'b0;
        is_load                = 1'b0;
        is_store               = 1'b0;
        writes_reg             = 1'b0;
        is_syscall             = 1'b0;
        illegal                = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                reg_dest = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: begin alu_operation = ALU_ADD;  writes_reg = 1'b1; end
                    FN_SUB:          begin alu_operation = ALU_SUB;  writes_reg = 1'b1; end
                    FN_AND:          begin alu_operation = ALU_AND;  writes_reg = 1'b1; end
                    FN_OR:           begin alu_operation = ALU_OR;   writes_reg = 1'b1; end
                    FN_XOR:          begin alu_operation = ALU_XOR;  writes_reg = 1'b1; end
                    FN_NOR:          begin alu_operation = ALU_NOR;  writes_reg = 1'b1; end
                    FN_SLT:          begin alu_operation = ALU_SLT;  writes_reg = 1'b1; end
                    FN_SLTU:         begin alu_operation = ALU_SLTU; writes_reg = 1'b1; end
                    FN_SLL: begin
                        alu_operation          = ALU_SLL;
                        does_shift_amount_need = 1'b1;
                        writes_reg             = 1'b1;
                    end
                    FN_SRL: begin
                        alu_operation          = ALU_SRL;
                        does_shift_amount_need = 1'b1;
                        writes_reg             = 1'b1;
                    end
                    FN_SRA: begin
                        alu_operation          = ALU_SRA;
                        does_shift_amount_need = 1'b1;
                        writes_reg             = 1'b1;
                    end
                    FN_JR:      jump_register = 1'b1;
                    FN_SYSCALL: is_syscall    = 1'b1;
                    default:    illegal       = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin alu_src = 1'b1; alu_operation = ALU_ADD; writes_reg = 1'b1; end
            OP_SLTI:           begin alu_src = 1'b1; alu_operation = ALU_SLT; writes_reg = 1'b1; end
            OP_ANDI: begin
                alu_src = 1'b1; is_unsigned = 1'b1; alu_operation = ALU_AND; writes_reg = 1'b1;
            end
            OP_ORI: begin
                alu_src = 1'b1; is_unsigned = 1'b1; alu_operation = ALU_OR;  writes_reg = 1'b1;
            end
            OP_XORI: begin
                alu_src = 1'b1; is_unsigned = 1'b1; alu_operation = ALU_XOR; writes_reg = 1'b1;
            end
            OP_LUI:  begin alu_src = 1'b1; alu_operation = ALU_LUI; writes_reg = 1'b1; end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_or_reg = 1'b1;
                is_mem     = 1'b1;
                is_load    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SW: begin
                alu_src  = 1'b1;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BEQ:  begin alu_operation = ALU_SUB; branch = zero;                 end
            OP_BNE:  begin alu_operation = ALU_SUB; branch = ~zero;                end
            OP_BLEZ: begin alu_operation = ALU_SUB; branch = zero | negative;      end
            OP_BGTZ: begin alu_operation = ALU_SUB; branch = ~zero & ~negative;    end
            OP_J:    jump = 1'b1;
            OP_JAL: begin
                jump       = 1'b1;
                pc_or_mem  = 1'b1;
                writes_reg = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing control for the MIPS-subset datapath.
//   clk, rst_b (async, active-low)
//   inst/inst_valid      : instruction word and instruction-memory handshake
//   zero/negative        : ALU flags for branch resolution
//   mem_ready            : data-memory completion handshake
//   selects              : reg_dest, alu_src, mem_or_reg, pc_or_mem, branch,
//                          jump, jump_register, does_shift_amount_need,
//                          is_unsigned, alu_operation[3:0]
//   strobes              : pc_we, reg_write_enable, mem_req, mem_we
//   status               : halted (sticky), illegal_inst (1-cycle pulse)
// Optional: define CTRL_PERF_CNT_EN to add instret[31:0] and
// stall_cycles[31:0] performance counters.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] inst,
    input  logic            inst_valid,
    input  logic            zero,
    input  logic            negative,
    input  logic            mem_ready,
    output logic            reg_dest,
    output logic            alu_src,
    output logic            mem_or_reg,
    output logic            pc_or_mem,
    output logic            branch,
    output logic            jump,
    output logic            jump_register,
    output logic            does_shift_amount_need,
    output logic            is_unsigned,
    output logic [3:0]      alu_operation,
    output logic            reg_write_enable,
    output logic            pc_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            halted,
    output logic            illegal_inst
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     instret,
    output logic [31:0]     stall_cycles
`endif
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic is_mem;
    logic is_load;
    logic is_store;
    logic writes_reg;
    logic is_syscall;
    logic illegal;

    inst_decoder #(
        .XLEN(XLEN)
    ) u_decoder (
        .inst                   (inst),
        .zero                   (zero),
        .negative               (negative),
        .reg_dest               (reg_dest),
        .alu_src                (alu_src),
        .mem_or_reg             (mem_or_reg),
        .pc_or_mem              (pc_or_mem),
        .branch                 (branch),
        .jump                   (jump),
        .jump_register          (jump_register),
        .does_shift_amount_need (does_shift_amount_need),
        .is_unsigned            (is_unsigned),
        .alu_operation          (alu_operation),
        .is_mem                 (is_mem),
        .is_load                (is_load),
        .is_store               (is_store),
        .writes_reg             (writes_reg),
        .is_syscall             (is_syscall),
        .illegal                (illegal)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are pure functions of the registered state, so an async reset
    // drops mem_req immediately and the pending access is simply abandoned.
    always_comb begin
        state_d          = state_q;
        pc_we            = 1'b0;
        reg_write_enable = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        halted           = 1'b0;
        illegal_inst     = 1'b0;

        case (state_q)
            FETCH: begin
                if (inst_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                illegal_inst = illegal;
                if (is_syscall) begin
                    state_d = HALT;
                end else if (is_mem) begin
                    state_d = MEM;
                end else begin
                    pc_we            = 1'b1;
                    reg_write_enable = writes_reg;
                    state_d          = FETCH;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    pc_we            = 1'b1;
                    reg_write_enable = is_load;
                    state_d          = FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q;
    logic [31:0] stall_q;
    logic        stall_now;

    // Neither term can be true in HALT, so the counters freeze there.
    assign stall_now = ((state_q == FETCH) && !inst_valid) ||
                       ((state_q == MEM)   && !mem_ready);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
            if (stall_now) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign instret      = instret_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the MIPS-subset datapath. It decodes the current instruction word and drives every datapath select and enable. It steps each instruction through fetch, execute and an optional memory phase, with ready/valid handshakes to instruction and data memory, so the datapath tolerates multi-cycle memories. It sits beside `data_path` in the core top level and owns the PC write enable, the register-file write enable and the data-memory request.

## Interface
Parameters:
- `XLEN`, 32: instruction and datapath width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `inst`  in  XLEN  instruction word at the current PC; stable while `pc_we`=0.
- `inst_valid`  in  1  instruction memory has `inst` ready.
- `zero`, `negative`  in  1 each  ALU flags from the datapath.
- `mem_ready`  in  1  data memory has completed the current access.
- `reg_dest`, `alu_src`, `mem_or_reg`, `pc_or_mem`, `branch`, `jump`, `jump_register`, `does_shift_amount_need`, `is_unsigned`  out  1 each  datapath selects.
- `alu_operation`  out  4  ALU opcode.
- `reg_write_enable`  out  1  register-file write strobe.
- `pc_we`  out  1  PC register write enable.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  data-memory write qualifier; valid only with `mem_req`.
- `halted`  out  1  sticky halt.
- `illegal_inst`  out  1  one-cycle pulse on an undecodable instruction.

## Operation
- State machine:
  - FETCH: wait for `inst_valid`, then go to EXEC.
  - EXEC: one cycle.
    - lw/sw go to MEM.
    - syscall (opcode 0x00, funct 0x0C) goes to HALT.
    - All other instructions commit in this cycle and go to FETCH.
  - MEM: hold `mem_req`=1. On `mem_ready`, commit and go to FETCH.
  - HALT: absorbing until reset.
- Commit cycle: `pc_we`=1. `reg_write_enable`=1 for register-writing instructions. Both are 0 in every other cycle.
- Select outputs are decoded combinationally from `inst` in every state. They are meaningful only in EXEC and MEM.
- Decode:
  - R-type funct codes: add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08.
  - I-type opcodes: addi 0x08, addiu 0x09, slti 0x0A, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, blez 0x06, bgtz 0x07.
  - Jump opcodes: j 0x02, jal 0x03.
- `alu_operation` encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11.
- Select rules:
  - `reg_dest`=1 for R-type.
  - `alu_src`=1 for I-type ALU ops and lw/sw.
  - `is_unsigned`=1 for andi/ori/xori.
  - `does_shift_amount_need`=1 for sll/srl/sra.
  - `mem_or_reg`=1 for lw.
  - `jump`=1 for j/jal.
  - `pc_or_mem`=1 for jal, which writes PC+4 to r31.
  - `jump_register`=1 for jr.
- Branches use ALU SUB and do not write a register. `branch` is the taken decision:
  - beq: `zero`.
  - bne: !`zero`.
  - blez: `zero`|`negative`.
  - bgtz: !`zero`&!`negative`.
- lw: `mem_we`=0, writes the register on the `mem_ready` commit. sw: `mem_we`=1, no register write.
- Unknown opcode or funct: `illegal_inst` pulses in EXEC and the instruction executes as a NOP (PC advances, no register write).
- `halted`=1 from entry to HALT onward. In HALT, `pc_we`, `reg_write_enable` and `mem_req` are all 0.

## Timing
- Reset: state FETCH. `pc_we`, `reg_write_enable`, `mem_req`, `mem_we`, `halted` and `illegal_inst` are all 0.
- Asserting reset mid-MEM drops `mem_req` asynchronously and discards the access.
- Latency, with instruction memory ready immediately:
  - ALU, branch and jump: 2 cycles.
  - lw/sw: 3 cycles plus N, where N is the number of cycles `mem_ready` is low in MEM.
- `mem_ready` is ignored outside MEM. If `mem_ready` is already high on MEM entry, commit happens in that same cycle.
- `inst_valid` is sampled only in FETCH.
- `mem_req` is asserted from the first MEM cycle through the `mem_ready` cycle inclusive. It deasserts the cycle after.

## Configuration
- `CTRL_PERF_CNT_EN` defined: adds outputs `instret` [31:0] and `stall_cycles` [31:0].
  - `instret` increments on every commit.
  - `stall_cycles` increments on every FETCH cycle with `inst_valid`=0 and every MEM cycle with `mem_ready`=0.
  - Both reset to 0, wrap modulo 2^32, and freeze in HALT.
- Not defined: the counters and ports do not exist.

## Structure
- Package `ctrl_pkg`: state enum (FETCH, EXEC, MEM, HALT), opcode and funct localparams, `alu_operation` encodings.
- Sub-module `inst_decoder`: purely combinational, maps `inst`, `zero` and `negative` to the select outputs plus class flags (is_mem, is_load, writes_reg, is_syscall, illegal).
- `multicycle_controller` holds the FSM, gating, and optional counters.

## Test plan
- Reset, then `add` (0x012A4020), `inst_valid`=1 → `pc_we`=1, `reg_write_enable`=1, `reg_dest`=1, `alu_operation`=0 in cycle 2 only.
- lw (0x8D090004) with `mem_ready` low for 3 MEM cycles → `mem_req` high 4 cycles; commit with `mem_or_reg`=1 and `reg_write_enable`=1 on the ready cycle; total 6 cycles.
- beq with `zero`=1, then bne with `zero`=1 → `branch`=1, then `branch`=0; `reg_write_enable`=0 both.
- jal (0x0C000010) → `jump`=1, `pc_or_mem`=1, `reg_write_enable`=1; syscall → `halted`=1 permanently, no `pc_we`.
- `rst_b` low during MEM → `mem_req` 0 immediately, state FETCH; opcode 0x3F → `illegal_inst` 1-cycle pulse, `pc_we`=1.
- With `CTRL_PERF_CNT_EN`: 5 instructions, 4 memory-wait cycles → `instret`=5, `stall_cycles`=4.
